// File: rtl/fp_pkg.sv
// Shared types and constants for the sequential floating-point add/sub datapath.
// Defaults match the half-precision-style 10-bit mantissa / 5-bit exponent configuration.
package fp_pkg;

    localparam int MANT_W_DEF = 10;
    localparam int EXP_W_DEF  = 5;
    localparam int GRS_W      = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        RND   = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Every field of a cleared / zero result takes this value.
    localparam logic RES_ZERO = 1'b0;

endpackage

// File: rtl/fp_align_shifter.sv
// Right barrel shifter for operand alignment; bits shifted past the LSB are OR-ed into bit 0 (sticky).
// Combinational, zero latency; no flow control.
// Shift amounts of W or more leave only the sticky bit.
import fp_pkg::*;

module fp_align_shifter #(
    parameter int W    = MANT_W_DEF + GRS_W,
    parameter int SH_W = EXP_W_DEF
) (
    input  logic [W-1:0]    din,
    input  logic [SH_W-1:0] shamt,
    output logic [W-1:0]    dout
);

    logic [2*W-1:0] wide;

    always_comb begin
        wide    = {din, {W{1'b0}}} >> shamt;
        dout    = wide[2*W-1:W];
        dout[0] = dout[0] | (|wide[W-1:0]);
        if (int'(shamt) >= W) begin
            dout = {{(W-1){1'b0}}, |din};
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle FP add/sub (swap, GRS align, add, iterative normalise); FP_ROUND_NEAREST_EN adds an RNE rounding state.
// Latency from capture: 4 cycles, +1 on carry, +k for k left shifts, +1 with rounding.
// One operation in flight: in_ready only while idle; the result is held until out_ready.
import fp_pkg::*;

module fp_addsub_seq #(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              op,
    input  logic              a_sgn,
    input  logic [EXP_W-1:0]  a_exp,
    input  logic [MANT_W-1:0] a_man,
    input  logic              b_sgn,
    input  logic [EXP_W-1:0]  b_exp,
    input  logic [MANT_W-1:0] b_man,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              r_sgn,
    output logic [EXP_W-1:0]  r_exp,
    output logic [MANT_W-1:0] r_man,
    output logic              ovf,
    output logic              uf
);

    localparam int EW = MANT_W + GRS_W;
    localparam int SW = EW + 1;

    typedef struct packed {
        logic              sgn;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] man;
    } opnd_t;

    typedef struct packed {
        logic              sgn;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] man;
        logic              ovf;
        logic              uf;
    } res_t;

    localparam res_t RES_CLR = res_t'({$bits(res_t){RES_ZERO}});

    state_t        state_q, state_d;
    opnd_t         a_q, b_q, big_q;
    logic          sml_sgn_q;
    logic [EW-1:0] sml_ext_q;
    logic [SW-1:0] sum_q;
    logic          sgn_q;
    logic [EXP_W-1:0] exp_q;
    res_t          res_q;

    // Magnitude compare: exponent first, then mantissa; ties keep A on top.
    logic             a_big;
    opnd_t            big_c, sml_c;
    logic [EXP_W-1:0] diff;
    logic [EW-1:0]    sml_sh;

    always_comb begin
        a_big = (a_q.exp > b_q.exp) || ((a_q.exp == b_q.exp) && (a_q.man >= b_q.man));
        big_c = a_big ? a_q : b_q;
        sml_c = a_big ? b_q : a_q;
        diff  = big_c.exp - sml_c.exp;
    end

    fp_align_shifter #(.W(EW), .SH_W(EXP_W)) u_align (
        .din   ({sml_c.man, {GRS_W{1'b0}}}),
        .shamt (diff),
        .dout  (sml_sh)
    );

    logic sum_zero, sum_carry, sum_msb, exp_max, exp_gt1, norm_ok;
    res_t res_sat, res_flush, res_norm;

    always_comb begin
        sum_zero  = (sum_q == '0);
        sum_carry = sum_q[SW-1];
        sum_msb   = sum_q[SW-2];
        exp_max   = &exp_q;
        exp_gt1   = exp_q > EXP_W'(1);
        norm_ok   = !sum_zero && !sum_carry && sum_msb;

        res_sat       = RES_CLR;
        res_sat.sgn   = sgn_q;
        res_sat.exp   = '1;
        res_sat.man   = '1;
        res_sat.ovf   = 1'b1;

        res_flush     = RES_CLR;
        res_flush.sgn = sgn_q;
        res_flush.uf  = 1'b1;

        res_norm      = RES_CLR;
        res_norm.sgn  = sgn_q;
        res_norm.exp  = exp_q;
        res_norm.man  = sum_q[SW-2:GRS_W];
    end

`ifdef FP_ROUND_NEAREST_EN
    logic              rnd_inc;
    logic [MANT_W:0]   rnd_man;
    res_t              res_rnd;

    always_comb begin
        rnd_inc     = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
        rnd_man     = {1'b0, sum_q[SW-2:GRS_W]} + {{MANT_W{1'b0}}, rnd_inc};
        res_rnd     = res_norm;
        res_rnd.man = rnd_man[MANT_W-1:0];
        if (rnd_man[MANT_W]) begin
            if (exp_max) begin
                res_rnd = res_sat;
            end else begin
                res_rnd.exp = exp_q + EXP_W'(1);
                res_rnd.man = {1'b1, {(MANT_W-1){1'b0}}};
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ALIGN;
            end
            ALIGN: state_d = ADD;
            ADD:   state_d = NORM;
            NORM: begin
                if (sum_zero || (sum_carry && exp_max) || (!sum_carry && !sum_msb && !exp_gt1)) begin
                    state_d = DONE;
                end else if (norm_ok) begin
`ifdef FP_ROUND_NEAREST_EN
                    state_d = RND;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef FP_ROUND_NEAREST_EN
            RND: state_d = DONE;
`endif
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            big_q     <= '0;
            sml_sgn_q <= 1'b0;
            sml_ext_q <= '0;
            sum_q     <= '0;
            sgn_q     <= 1'b0;
            exp_q     <= '0;
            res_q     <= RES_CLR;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q <= {a_sgn, a_exp, a_man};
                    b_q <= {b_sgn ^ op, b_exp, b_man};
                end
                ALIGN: begin
                    big_q     <= big_c;
                    sml_sgn_q <= sml_c.sgn;
                    sml_ext_q <= sml_sh;
                end
                ADD: begin
                    sgn_q <= big_q.sgn;
                    exp_q <= big_q.exp;
                    if (big_q.sgn != sml_sgn_q)
                        sum_q <= {1'b0, big_q.man, {GRS_W{1'b0}}} - {1'b0, sml_ext_q};
                    else
                        sum_q <= {1'b0, big_q.man, {GRS_W{1'b0}}} + {1'b0, sml_ext_q};
                end
                NORM: begin
                    if (sum_zero) begin
                        res_q <= RES_CLR;
                    end else if (sum_carry) begin
                        if (exp_max) begin
                            res_q <= res_sat;
                        end else begin
                            sum_q <= {1'b0, sum_q[SW-1:2], |sum_q[1:0]};
                            exp_q <= exp_q + EXP_W'(1);
                        end
                    end else if (!sum_msb) begin
                        if (exp_gt1) begin
                            sum_q <= sum_q << 1;
                            exp_q <= exp_q - EXP_W'(1);
                        end else begin
                            res_q <= res_flush;
                        end
                    end
`ifndef FP_ROUND_NEAREST_EN
                    else begin
                        res_q <= res_norm;
                    end
`endif
                end
`ifdef FP_ROUND_NEAREST_EN
                RND: res_q <= res_rnd;
`endif
                default: ;
            endcase
        end
    end

    assign r_sgn = res_q.sgn;
    assign r_exp = res_q.exp;
    assign r_man = res_q.man;
    assign ovf   = res_q.ovf;
    assign uf    = res_q.uf;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq (MANT_W=10, EXP_W=5): results, flags, latency, handshake, reset.
module tb_fp_addsub_seq;

`ifdef FP_ROUND_NEAREST_EN
    localparam int RL = 1;
`else
    localparam int RL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, op;
    logic       a_sgn, b_sgn;
    logic [4:0] a_exp, b_exp;
    logic [9:0] a_man, b_man;
    logic       out_valid, out_ready;
    logic       r_sgn;
    logic [4:0] r_exp;
    logic [9:0] r_man;
    logic       ovf, uf;

    int chk  = 0;
    int pass = 0;

    fp_addsub_seq #(.MANT_W(10), .EXP_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a_sgn     (a_sgn),
        .a_exp     (a_exp),
        .a_man     (a_man),
        .b_sgn     (b_sgn),
        .b_exp     (b_exp),
        .b_man     (b_man),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r_sgn     (r_sgn),
        .r_exp     (r_exp),
        .r_man     (r_man),
        .ovf       (ovf),
        .uf        (uf)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] res();
        return {r_sgn, r_exp, r_man, ovf, uf};
    endfunction

    task automatic drive(input logic o, input logic as, input logic [4:0] ae, input logic [9:0] am,
                         input logic bs, input logic [4:0] be, input logic [9:0] bm);
        op = o; a_sgn = as; a_exp = ae; a_man = am; b_sgn = bs; b_exp = be; b_man = bm;
    endtask

    // Issues one operation from idle and waits (bounded) for out_valid; lat counts edges incl. capture.
    task automatic run_op(input logic o, input logic as, input logic [4:0] ae, input logic [9:0] am,
                          input logic bs, input logic [4:0] be, input logic [9:0] bm, output int lat);
        @(negedge clk);
        drive(o, as, ae, am, bs, be, bm);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        chk++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL reset_hs: got %b want 10", {in_ready, out_valid});
        else pass++;
        chk++;
        if (res() !== 18'h0) $display("FAIL reset_res: got %h want %h", res(), 18'h0);
        else pass++;
    endtask

    task automatic test_add();
        int lat;
        run_op(1'b0, 1'b0, 5'd15, 10'h200, 1'b0, 5'd15, 10'h200, lat);
        chk++;
        if (out_valid !== 1'b1 || lat != 5 + RL) $display("FAIL add_lat: got %0d valid %b want %0d", lat, out_valid, 5 + RL);
        else pass++;
        chk++;
        if (res() !== {1'b0, 5'd16, 10'h200, 2'b00}) $display("FAIL add_res: got %h want %h", res(), {1'b0, 5'd16, 10'h200, 2'b00});
        else pass++;
        consume();
    endtask

    task automatic test_sub_norm();
        int lat;
        run_op(1'b1, 1'b0, 5'd15, 10'h300, 1'b0, 5'd15, 10'h200, lat);
        chk++;
        if (out_valid !== 1'b1 || lat != 5 + RL) $display("FAIL sub1_lat: got %0d valid %b want %0d", lat, out_valid, 5 + RL);
        else pass++;
        chk++;
        if (res() !== {1'b0, 5'd14, 10'h200, 2'b00}) $display("FAIL sub1_res: got %h want %h", res(), {1'b0, 5'd14, 10'h200, 2'b00});
        else pass++;
        consume();
        // 0x3FF - 0x3FE leaves one bit at the mantissa LSB: nine left shifts.
        run_op(1'b1, 1'b0, 5'd15, 10'h3FF, 1'b0, 5'd15, 10'h3FE, lat);
        chk++;
        if (out_valid !== 1'b1 || lat != 13 + RL) $display("FAIL sub9_lat: got %0d valid %b want %0d", lat, out_valid, 13 + RL);
        else pass++;
        chk++;
        if (res() !== {1'b0, 5'd6, 10'h200, 2'b00}) $display("FAIL sub9_res: got %h want %h", res(), {1'b0, 5'd6, 10'h200, 2'b00});
        else pass++;
        consume();
        // B larger than A under subtraction: swapped, negative result.
        run_op(1'b1, 1'b0, 5'd15, 10'h200, 1'b0, 5'd15, 10'h300, lat);
        chk++;
        if (res() !== {1'b1, 5'd14, 10'h200, 2'b00}) $display("FAIL subneg_res: got %h want %h", res(), {1'b1, 5'd14, 10'h200, 2'b00});
        else pass++;
        consume();
    endtask

    task automatic test_cancel();
        int lat;
        run_op(1'b1, 1'b0, 5'd15, 10'h200, 1'b0, 5'd15, 10'h200, lat);
        chk++;
        if (out_valid !== 1'b1 || lat != 4) $display("FAIL cancel_lat: got %0d valid %b want 4", lat, out_valid);
        else pass++;
        chk++;
        if (res() !== 18'h0) $display("FAIL cancel_sub_res: got %h want %h", res(), 18'h0);
        else pass++;
        consume();
        run_op(1'b0, 1'b0, 5'd15, 10'h200, 1'b1, 5'd15, 10'h200, lat);
        chk++;
        if (res() !== 18'h0) $display("FAIL cancel_neg_res: got %h want %h", res(), 18'h0);
        else pass++;
        consume();
    endtask

    task automatic test_underflow();
        int lat;
        run_op(1'b1, 1'b0, 5'd1, 10'h300, 1'b0, 5'd1, 10'h200, lat);
        chk++;
        if (out_valid !== 1'b1 || lat != 4) $display("FAIL uf_lat: got %0d valid %b want 4", lat, out_valid);
        else pass++;
        chk++;
        if (res() !== {1'b0, 5'd0, 10'h000, 2'b01}) $display("FAIL uf_res: got %h want %h", res(), {1'b0, 5'd0, 10'h000, 2'b01});
        else pass++;
        consume();
    endtask

    task automatic test_swap_large();
        int lat;
        run_op(1'b0, 1'b0, 5'd2, 10'h200, 1'b0, 5'd15, 10'h200, lat);
        chk++;
        if (out_valid !== 1'b1 || lat != 4 + RL) $display("FAIL swap_lat: got %0d valid %b want %0d", lat, out_valid, 4 + RL);
        else pass++;
        chk++;
        if (res() !== {1'b0, 5'd15, 10'h200, 2'b00}) $display("FAIL swap_res: got %h want %h", res(), {1'b0, 5'd15, 10'h200, 2'b00});
        else pass++;
        consume();
        // diff 10: B contributes G=1,R=1 only; truncation keeps 0x200, nearest-even gives 0x201.
        run_op(1'b0, 1'b0, 5'd15, 10'h200, 1'b0, 5'd5, 10'h300, lat);
        chk++;
        if (res() !== {1'b0, 5'd15, (RL == 1) ? 10'h201 : 10'h200, 2'b00})
            $display("FAIL grs_res: got %h want %h", res(), {1'b0, 5'd15, (RL == 1) ? 10'h201 : 10'h200, 2'b00});
        else pass++;
        consume();
    endtask

    task automatic test_overflow();
        int lat;
        run_op(1'b0, 1'b0, 5'd31, 10'h3FF, 1'b0, 5'd31, 10'h3FF, lat);
        chk++;
        if (out_valid !== 1'b1 || lat != 4) $display("FAIL ovf_lat: got %0d valid %b want 4", lat, out_valid);
        else pass++;
        chk++;
        if (res() !== {1'b0, 5'd31, 10'h3FF, 2'b10}) $display("FAIL ovf_res: got %h want %h", res(), {1'b0, 5'd31, 10'h3FF, 2'b10});
        else pass++;
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(1'b0, 1'b0, 5'd15, 10'h200, 1'b0, 5'd15, 10'h200, lat);
        drive(1'b0, 1'b0, 5'd31, 10'h3FF, 1'b0, 5'd31, 10'h3FF);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk++;
            if ({out_valid, in_ready} !== 2'b10 || res() !== {1'b0, 5'd16, 10'h200, 2'b00})
                $display("FAIL hold_%0d: got v%b r%b %h want v1 r0 %h", i, out_valid, in_ready, res(), {1'b0, 5'd16, 10'h200, 2'b00});
            else pass++;
        end
        // Consume with in_valid still high: the block must land in IDLE without capturing.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL consume_idle: got v%b r%b want v0 r1", out_valid, in_ready);
        else pass++;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen;
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd15, 10'h3FF, 1'b0, 5'd15, 10'h3FE);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk++;
        if ({out_valid, in_ready} !== 2'b00) $display("FAIL busy_norm: got v%b r%b want v0 r0", out_valid, in_ready);
        else pass++;
        rst = 1'b1;
        #1;
        chk++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL rst_mid_hs: got v%b r%b want v0 r1", out_valid, in_ready);
        else pass++;
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk++;
        if (seen !== 1'b0) $display("FAIL rst_mid_discard: got out_valid 1 want 0");
        else pass++;
        run_op(1'b0, 1'b0, 5'd15, 10'h200, 1'b0, 5'd15, 10'h200, lat);
        chk++;
        if (out_valid !== 1'b1 || res() !== {1'b0, 5'd16, 10'h200, 2'b00})
            $display("FAIL after_rst: got v%b %h want v1 %h", out_valid, res(), {1'b0, 5'd16, 10'h200, 2'b00});
        else pass++;
        consume();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 10'h0, 1'b0, 5'd0, 10'h0);
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_add();
        test_sub_norm();
        test_cancel();
        test_underflow();
        test_swap_large();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
- Multi-cycle, parametrised floating-point adder/subtractor with a valid/ready handshake on input and output.
- Successor to the combinational mantissa/exponent adder. Adds:
  - operand swap by magnitude
  - true subtraction mode
  - guard/round/sticky alignment
  - iterative normalisation
  - overflow/underflow flags
- Sits between operand registers and the result writeback in the FP datapath.

Parameters:
- MANT_W, 10, mantissa width including the explicit leading (integer) bit at MSB.
- EXP_W, 5, biased exponent width (bias is not used internally; exponents compared/adjusted raw).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- op  in  1  0 = A+B, 1 = A-B.
- a_sgn  in  1  sign of A.
- a_exp  in  EXP_W  exponent of A.
- a_man  in  MANT_W  mantissa of A.
- b_sgn  in  1  sign of B.
- b_exp  in  EXP_W  exponent of B.
- b_man  in  MANT_W  mantissa of B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- r_sgn  out  1  result sign.
- r_exp  out  EXP_W  result exponent.
- r_man  out  MANT_W  result mantissa, normalised (MSB=1) unless zero.
- ovf  out  1  exponent overflow; valid with out_valid.
- uf  out  1  underflow / flush-to-zero; valid with out_valid.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE
  - in_ready=1, out_valid=0
  - r_sgn, r_exp, r_man, ovf, uf all 0
  - reset mid-operation discards the operation; no partial result is emitted.
- Handshake:
  - in_ready=1 only in IDLE.
  - Operands are captured on the edge where in_valid&&in_ready.
  - out_valid=1 only in DONE; outputs are held stable until out_valid&&out_ready, then IDLE.
  - No new input is accepted in the same cycle a result is consumed.
- States: IDLE -> ALIGN -> ADD -> NORM (1..MANT_W+1 cycles) -> [RND if ROUND_EN] -> DONE -> IDLE.
- ALIGN:
  - Effective B sign is b_sgn^op.
  - Swap so that A has the larger magnitude: compare exponent first, then mantissa; on a tie A stays A.
  - diff = expA - expB (unsigned after swap).
  - B is extended with 3 bits G,R,S and shifted right by diff, in one cycle.
  - Shifted-out bits are OR-ed into S.
  - If diff >= MANT_W+3, B becomes all-zero except S = |b_man.
- ADD:
  - Effective subtract when sgnA != effective sgnB.
  - Sum width is MANT_W+1+3 (carry bit, mantissa, GRS).
  - Result sign = sgnA; exponent register = expA.
- NORM (evaluated in this order each cycle):
  1. Sum==0: result is +0 (sgn=0, exp=0, man=0). Go to DONE.
  2. Carry set: shift right 1 (LSB OR-ed into S), exp+1. If exp was all-ones: saturate exp=all-ones, man=all-ones, ovf=1, go to DONE.
  3. MSB=0 and exp>1: shift left 1, exp-1, stay in NORM.
  4. MSB=0 and exp<=1: flush to zero (sign kept), uf=1, go to DONE.
  5. Otherwise the result is normalised: go to RND/DONE.
- Rounding without ROUND_EN: truncate (GRS discarded).
- Latency from capture edge to out_valid:
  - 4 cycles, no shift needed
  - 5 cycles on carry
  - 4+k cycles for k left shifts
  - +1 cycle with ROUND_EN.

Optional Feature:
- Macro: FP_ROUND_NEAREST_EN.
- Defined:
  - Adds the RND state, which applies round-to-nearest-even: increment when G && (R||S||LSB).
  - If the increment overflows the mantissa: man = 100..0, exp+1 in the same cycle, with the overflow check as in NORM.
- Undefined:
  - RND state and logic are absent; results are truncated.

Decomposition:
- Shared package fp_pkg holds:
  - default MANT_W/EXP_W
  - GRS_W=3
  - state encoding constants IDLE/ALIGN/ADD/NORM/RND/DONE
  - the zero-result constant.
- Sub-module fp_align_shifter: a combinational right barrel shifter (MANT_W+3 bits, shift amount EXP_W bits) producing the sticky OR. It replaces the old fixed-width shifter.

Test Plan (MANT_W=10, EXP_W=5):
- Add: 1.0+1.0 (man 0x200, exp 15, both) -> 0x200, exp 16, sgn 0, ovf=0, latency 5.
- Subtract with normalise: 1.5-1.0 (0x300/15 minus 0x200/15) -> 0x200, exp 14, latency 5 (one left shift).
- Exact cancellation: 1.0-1.0 -> sgn 0, exp 0, man 0, uf=0; also A=0x200/15 with op=0, b_sgn=1 gives the same result.
- Swap and large diff: A=0x200/exp 2, B=0x200/exp 15, add -> 0x200, exp 15 (B dominant, diff 13 ≥ 13 so the small operand is sticky-only). With FP_ROUND_NEAREST_EN the result is unchanged.
- Overflow: 0x3FF/31 + 0x3FF/31 -> exp 31, man 0x3FF, ovf=1.
- Handshake and reset:
  - Hold out_ready=0 for 3 cycles: outputs stable, in_ready=0 throughout.
  - Assert rst mid-NORM: in_ready=1 and out_valid=0 immediately.
  - The next operation after reset completes correctly.
